// File: rtl/mc_fifo_bank_if.sv
// Push/pop/status bundle for the multi-channel FIFO bank.
// The sticky error outputs (ovf/udf) exist only when MC_FIFO_BANK_ERR_EN is defined.
interface mc_fifo_bank_if #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 32,
    parameter int NCH   = 4
);
    localparam int CHW = $clog2(NCH);
    localparam int CW  = $clog2(SIZE) + 1;

    logic                push;
    logic [CHW-1:0]      push_ch;
    logic [WIDTH-1:0]    wdata;
    logic                pop;
    logic [CHW-1:0]      pop_ch;
    logic [NCH-1:0]      flush;
    logic [WIDTH-1:0]    rdata;
    logic                valid;
    logic [NCH-1:0]      full;
    logic [NCH-1:0]      empty;
    logic [NCH-1:0]      al_full;
    logic [NCH*CW-1:0]   count;
`ifdef MC_FIFO_BANK_ERR_EN
    logic [NCH-1:0]      ovf;
    logic [NCH-1:0]      udf;
`endif

    // Requester side: drives requests, observes data and status.
    modport master (
`ifdef MC_FIFO_BANK_ERR_EN
        input  ovf,
        input  udf,
`endif
        output push,
        output push_ch,
        output wdata,
        output pop,
        output pop_ch,
        output flush,
        input  rdata,
        input  valid,
        input  full,
        input  empty,
        input  al_full,
        input  count
    );

    // FIFO bank side.
    modport slave (
`ifdef MC_FIFO_BANK_ERR_EN
        output ovf,
        output udf,
`endif
        input  push,
        input  push_ch,
        input  wdata,
        input  pop,
        input  pop_ch,
        input  flush,
        output rdata,
        output valid,
        output full,
        output empty,
        output al_full,
        output count
    );
endinterface

// File: rtl/mc_fifo_bank.sv
// mc_fifo_bank: NCH independent circular FIFOs sharing one push and one pop port.
// All channels live in one storage array addressed by {channel, pointer}; the read
// port is registered so the array maps onto block RAM. Status is registered from
// the post-update count. Optional macro MC_FIFO_BANK_ERR_EN adds sticky per-channel
// overflow/underflow flags.
module mc_fifo_bank #(
    parameter int WIDTH     = 16,
    parameter int SIZE      = 32,
    parameter int NCH       = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic           clk,
    input  logic           rst,
    mc_fifo_bank_if.slave  bus
);
    localparam int CHW = $clog2(NCH);
    localparam int PW  = $clog2(SIZE);
    localparam int CW  = PW + 1;
    localparam int AW  = CHW + PW;
    localparam bit NCH_POW2 = (NCH == (1 << CHW));

    logic [WIDTH-1:0] mem [NCH*SIZE];

    logic [NCH-1:0] full_vec;
    logic [NCH-1:0] empty_vec;
    logic [PW-1:0]  wr_ptr_vec [NCH];
    logic [PW-1:0]  rd_ptr_vec [NCH];

    logic [WIDTH-1:0] rdata_reg;
    logic             valid_reg;

    logic push_ch_ok;
    logic pop_ch_ok;
    logic push_ok;
    logic pop_ok;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    // With a non-power-of-two channel count, indices past NCH-1 are ignored.
    assign push_ch_ok = NCH_POW2 || (int'(bus.push_ch) < NCH);
    assign pop_ch_ok  = NCH_POW2 || (int'(bus.pop_ch) < NCH);

    // Acceptance uses the registered (pre-cycle) status, so a full channel rejects
    // a push even when it is popped in the same cycle, and vice versa.
    assign push_ok = bus.push && push_ch_ok && !full_vec[bus.push_ch]  && !bus.flush[bus.push_ch];
    assign pop_ok  = bus.pop  && pop_ch_ok  && !empty_vec[bus.pop_ch] && !bus.flush[bus.pop_ch];

    assign waddr = {bus.push_ch, wr_ptr_vec[bus.push_ch]};
    assign raddr = {bus.pop_ch,  rd_ptr_vec[bus.pop_ch]};

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[waddr] <= bus.wdata;
        end
    end

    // Registered read port and valid strobe; rdata holds when no pop is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= pop_ok;
            if (pop_ok) begin
                rdata_reg <= mem[raddr];
            end
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.valid = valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [PW-1:0] wr_ptr_reg;
            logic [PW-1:0] rd_ptr_reg;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          full_reg;
            logic          empty_reg;
            logic          af_reg;
            logic          push_hit;
            logic          pop_hit;

            assign push_hit = push_ok && (bus.push_ch == CHW'(gi));
            assign pop_hit  = pop_ok  && (bus.pop_ch  == CHW'(gi));

            // Post-update occupancy; a simultaneous push and pop leaves it unchanged.
            always_comb begin
                cnt_next = cnt_reg;
                if (push_hit && !pop_hit) begin
                    cnt_next = cnt_reg + CW'(1);
                end else if (!push_hit && pop_hit) begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end

            // Pointer, count and registered status update; flush empties the channel.
            always_ff @(posedge clk) begin
                if (rst || bus.flush[gi]) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                    full_reg   <= 1'b0;
                    empty_reg  <= 1'b1;
                    af_reg     <= 1'b0;
                end else begin
                    if (push_hit) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (pop_hit) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                    cnt_reg   <= cnt_next;
                    full_reg  <= (cnt_next == CW'(SIZE));
                    empty_reg <= (cnt_next == '0);
                    af_reg    <= (cnt_next >= CW'(SIZE - AF_MARGIN));
                end
            end

            assign full_vec[gi]          = full_reg;
            assign empty_vec[gi]         = empty_reg;
            assign wr_ptr_vec[gi]        = wr_ptr_reg;
            assign rd_ptr_vec[gi]        = rd_ptr_reg;
            assign bus.full[gi]          = full_reg;
            assign bus.empty[gi]         = empty_reg;
            assign bus.al_full[gi]       = af_reg;
            assign bus.count[gi*CW +: CW] = cnt_reg;

`ifdef MC_FIFO_BANK_ERR_EN
            logic ovf_reg;
            logic udf_reg;
            logic push_drop;
            logic pop_drop;

            // Only capacity drops count; flush-induced drops are excluded.
            assign push_drop = bus.push && push_ch_ok && (bus.push_ch == CHW'(gi))
                               && full_reg && !bus.flush[gi];
            assign pop_drop  = bus.pop && pop_ch_ok && (bus.pop_ch == CHW'(gi))
                               && empty_reg && !bus.flush[gi];

            // Sticky error flags, cleared by reset or by flushing the channel.
            always_ff @(posedge clk) begin
                if (rst || bus.flush[gi]) begin
                    ovf_reg <= 1'b0;
                    udf_reg <= 1'b0;
                end else begin
                    if (push_drop) begin
                        ovf_reg <= 1'b1;
                    end
                    if (pop_drop) begin
                        udf_reg <= 1'b1;
                    end
                end
            end

            assign bus.ovf[gi] = ovf_reg;
            assign bus.udf[gi] = udf_reg;
`endif
        end
    endgenerate

endmodule
